sa_out_scheduler: RTL



---
 rtl/sa_out_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sa_out_scheduler.sv
// sa_out_scheduler: round-robin, credit-gated scheduler for one output port; define SA_SCHED_WORMHOLE_EN for head/tail packet locking
module sa_out_scheduler #(
    parameter int CREDITS = 8,
    localparam int CW = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    req,
    input  logic [9:0]    flit_type,
    input  logic          wfull,
    input  logic          credit_ret,
    output logic [4:0]    grant,
    output logic          winc,
    output logic [CW-1:0] credit_cnt,
    output logic          locked
);

    logic [2:0] rr_ptr;
    logic [2:0] rr_nx;
    logic [2:0] winner;
    logic [3:0] idx;
    logic       found;
    logic       gate;

    function automatic logic [2:0] nxt(input logic [2:0] x);
        return (x == 3'd4) ? 3'd0 : x + 3'd1;
    endfunction

    assign gate = (credit_cnt != '0) && !wfull;
    assign winc = |(grant & req);

    // first requester found scanning from rr_ptr, wrapping modulo 5
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        idx    = 4'd0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            idx = (idx >= 4'd5) ? idx - 4'd5 : idx;
            if (!found && req[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

`ifdef SA_SCHED_WORMHOLE_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t     state;
    state_t     state_nx;
    logic [2:0] owner;
    logic [2:0] owner_nx;
    logic [1:0] ft;

    assign locked = (state == LOCKED);
    assign ft     = 2'(flit_type >> {locked ? owner : winner, 1'b0});

    // while locked only the owner may send; otherwise the round-robin winner
    always_comb begin
        grant = 5'd0;
        if (gate)
            grant = locked ? (req[owner] ? 5'(1) << owner : 5'd0)
                           : (found ? 5'(1) << winner : 5'd0);
    end

    // head takes the lock, tail releases it and moves priority past the owner
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        if (winc) begin
            if (locked) begin
                if (ft == 2'b11) begin
                    state_nx = IDLE;
                    rr_nx    = nxt(owner);
                end
            end else if (ft == 2'b01) begin
                state_nx = LOCKED;
                owner_nx = winner;
            end else begin
                rr_nx = nxt(winner);
            end
        end
    end

    // arbitration state register; reset drops any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= 3'd0;
            rr_ptr <= 3'd0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_nx;
        end
    end
`else
    logic unused_flit_type;

    assign unused_flit_type = ^flit_type;
    assign locked           = 1'b0;
    assign grant            = (gate && found) ? 5'(1) << winner : 5'd0;
    assign rr_nx            = winc ? nxt(winner) : rr_ptr;

    // every granted flit is a single flit, so priority moves on each write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= 3'd0;
        else        rr_ptr <= rr_nx;
    end
`endif

    // credit counter: write spends one, return restores one, saturating at CREDITS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            credit_cnt <= CW'(CREDITS);
        else if (winc && !credit_ret)
            credit_cnt <= credit_cnt - CW'(1);
        else if (!winc && credit_ret && credit_cnt != CW'(CREDITS))
            credit_cnt <= credit_cnt + CW'(1);
    end

endmodule
